data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
- REQ-001 DWIDTH, 16, data word width in bits.
- REQ-002 AWIDTH, 16, address width in bits.
- REQ-003 DEPTH, 256, number of storage words; power of two, at most 2^AWIDTH.
- REQ-004 LATENCY, 2, clock edges from request acceptance to response; legal range 1..15.
- REQ-005 clk  input  1  single clock; all logic on rising edge.
- REQ-006 rst  input  1  reset, synchronous, active-high.
- REQ-007 ram_en  input  1  request strobe from the CPU data port.
- REQ-008 wen  input  1  1 = write request, 0 = read request; qualified by ram_en.
- REQ-009 ram_addr  input  AWIDTH  word address.
- REQ-010 w_ram_data  input  DWIDTH  write data.
- REQ-011 r_ram_data  output  DWIDTH  read data; valid when ram_valid is high after a read.
- REQ-012 ram_valid  output  1  one-cycle completion pulse for a read or a write.
- REQ-013 busy  output  1  high while a request is in flight.
- REQ-014 addr_err  output  1  out-of-range flag; exists only under DMEM_ADDR_CHECK_EN.

Function
- REQ-015 States: IDLE, WAIT, RESP.
- REQ-016 A request is accepted on a rising edge where state = IDLE and ram_en = 1; wen, ram_addr and w_ram_data are captured on that edge.
- REQ-017 ram_en is ignored in WAIT and RESP; no queueing, no error.
- REQ-018 After acceptance, an internal counter loads LATENCY-1; the FSM enters WAIT, or RESP directly when LATENCY = 1.
- REQ-019 WAIT decrements the counter each edge and moves to RESP when the counter reaches 0.
- REQ-020 ram_valid is high exactly in the RESP cycle, i.e. LATENCY edges after the accepting edge; RESP always returns to IDLE next edge.
- REQ-021 Writes commit to storage on the edge leaving RESP.
- REQ-022 For reads, r_ram_data is loaded from storage on the edge entering RESP.
- REQ-023 r_ram_data holds its value until the next read response; writes do not change it.
- REQ-024 A read of an address being written by the previous request returns the new data, because the write commits before the next acceptance.
- REQ-025 busy = (state != IDLE).
- REQ-026 Minimum request spacing is LATENCY+1 cycles; ram_en held high continuously yields one request per LATENCY+1 cycles.
- REQ-027 Address index = ram_addr modulo DEPTH (low log2(DEPTH) bits) unless REQ-033 applies.

Reset
- REQ-028 On the rising edge with rst = 1: state is IDLE, counter is 0, ram_valid is 0, busy is 0, r_ram_data is 0, and addr_err is 0.
- REQ-029 Reset mid-operation aborts the request: no ram_valid pulse and no write commit.
- REQ-030 rst and ram_en on the same edge: reset wins and the request is dropped.
- REQ-031 Storage contents are not cleared by reset.

Configuration
- REQ-032 Macro DMEM_ADDR_CHECK_EN controls address range checking.
- REQ-033 With DMEM_ADDR_CHECK_EN defined, a request with ram_addr >= DEPTH is handled as follows:
  - it completes with normal timing;
  - addr_err is high in its RESP cycle only;
  - a write is suppressed;
  - a read returns 0.
- REQ-034 Without DMEM_ADDR_CHECK_EN, the addr_err port is absent and addresses wrap per REQ-027.

Structure
- REQ-035 Shared package dmem_pkg holds the state enumeration (IDLE/WAIT/RESP) and default constants DMEM_DEPTH = 256 and DMEM_LATENCY = 2.
- REQ-036 Storage is a sub-module dmem_array: single port, synchronous write, DEPTH x DWIDTH, with inputs we, idx, wdata and output rdata.
- REQ-037 The FSM and counter live in data_mem_ctrl.

Verification
- REQ-038 Default parameters; write 0x1234 to address 5, then read address 5.
  - Write: ram_valid pulses 2 edges after acceptance.
  - Read: r_ram_data = 0x1234 with ram_valid.
- REQ-039 ram_en held high for 12 cycles while reading.
  - Exactly 4 requests are accepted, one every 3 cycles.
  - busy has a 2-cycle-high, 1-cycle-low pattern.
- REQ-040 Write 0xBEEF to address 7, assert rst in the WAIT cycle, then read address 7.
  - No ram_valid pulse after the reset.
  - The read returns the prior contents, not 0xBEEF.
- REQ-041 LATENCY = 1; write 0xAAAA to address 3, then immediately read address 3.
  - ram_valid pulses one edge after each acceptance.
  - The read returns 0xAAAA.
- REQ-042 DMEM_ADDR_CHECK_EN defined; write 0x5555 to address 256, then read address 0.
  - addr_err pulses in the write's RESP cycle.
  - Address 0 is unchanged.
  - A read of address 256 returns 0.
- REQ-043 DMEM_ADDR_CHECK_EN undefined; write 0x5555 to address 256.
  - A read of address 0 returns 0x5555 (wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: FSM states and default sizing.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEPTH   = 256;
    localparam int DMEM_LATENCY = 2;
    // Wide enough for the largest supported LATENCY of 15.
    localparam int DMEM_CNT_W   = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x DWIDTH storage: synchronous write, combinational read of the same index.
module dmem_array #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency CPU data memory controller (IDLE/WAIT/RESP FSM around dmem_array).
// Optional address range checking and the addr_err port are enabled by DMEM_ADDR_CHECK_EN.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 16,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic              wen,
    input  logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] w_ram_data,
    output logic [DWIDTH-1:0] r_ram_data,
    output logic              ram_valid,
    output logic              busy,
`ifdef DMEM_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    output dmem_state_e       dbg_state
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DWIDTH-1:0]     wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DWIDTH-1:0]     rdata_q, rdata_d;

    logic                  accept;
    logic                  in_err;
    logic                  rd_load;
    logic                  arr_we;
    logic [IW-1:0]         arr_idx;
    logic [DWIDTH-1:0]     arr_rdata;
    logic                  unused_addr_bits;

`ifdef DMEM_ADDR_CHECK_EN
    localparam logic [AWIDTH:0] DEPTH_A = (AWIDTH + 1)'(DEPTH);
    assign in_err = ({1'b0, ram_addr} >= DEPTH_A);
`else
    assign in_err = 1'b0;
`endif
    // Upper address bits only matter for range checking; otherwise addresses wrap.
    assign unused_addr_bits = ^ram_addr;

    assign accept = (state_q == IDLE) && ram_en;

    // State register; request fields are held without reset since they are only used in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        wen_q   <= wen_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ram_en) begin
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    wen_d   = wen;
                    idx_d   = ram_addr[IW-1:0];
                    wdata_d = w_ram_data;
                    err_d   = in_err;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads sample storage on the edge entering RESP; out-of-range reads return zero.
    always_comb begin
        rd_load = (state_d == RESP) && (state_q != RESP) && !wen_d;
        rdata_d = rdata_q;
        if (rd_load) begin
            rdata_d = err_d ? '0 : arr_rdata;
        end
        arr_idx   = accept ? ram_addr[IW-1:0] : idx_q;
        arr_we    = (state_q == RESP) && wen_q && !err_q && !rst;
        ram_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = (state_q == RESP) && err_q;
`endif

    assign r_ram_data = rdata_q;

    dmem_array #(
        .DWIDTH(DWIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .idx  (arr_idx),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one LATENCY=2 and one LATENCY=1 instance, random and directed
// transactions checked against a word-array memory model and the fixed-latency timing rules.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [1:0]        en, wen_s, valid, busy, aerr;
    logic [1:0][15:0]  addr, wdata, rdata;
    dmem_state_e       st0, st1;

    logic [15:0] model_mem [2][256];
    logic [15:0] last_rd [2];
    int          checks   = 0;
    int          failures = 0;

    data_mem_ctrl #(.LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .ram_en(en[0]), .wen(wen_s[0]), .ram_addr(addr[0]),
        .w_ram_data(wdata[0]), .r_ram_data(rdata[0]), .ram_valid(valid[0]), .busy(busy[0]),
`ifdef DMEM_ADDR_CHECK_EN
        .addr_err(aerr[0]),
`endif
        .dbg_state(st0)
    );

    data_mem_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ram_en(en[1]), .wen(wen_s[1]), .ram_addr(addr[1]),
        .w_ram_data(wdata[1]), .r_ram_data(rdata[1]), .ram_valid(valid[1]), .busy(busy[1]),
`ifdef DMEM_ADDR_CHECK_EN
        .addr_err(aerr[1]),
`endif
        .dbg_state(st1)
    );

`ifndef DMEM_ADDR_CHECK_EN
    assign aerr = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    function automatic bit out_of_range(input logic [15:0] a);
        return CHK && (a >= 16'd256);
    endfunction

    // One complete request on instance s; called at a falling edge with the instance idle.
    task automatic do_req(input int s, input bit w, input logic [15:0] a, input logic [15:0] d);
        int k;
        logic [15:0] exp_rd;
        en[s] = 1'b1; wen_s[s] = w; addr[s] = a; wdata[s] = d;
        @(posedge clk);
        @(negedge clk);
        en[s] = 1'b0;
        check_eq("busy_after_accept", 32'(busy[s]), 32'd1);
        k = 1;
        while (!valid[s] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("valid_latency", k, lat_of(s));
        exp_rd = w ? last_rd[s] : (out_of_range(a) ? 16'h0 : model_mem[s][a[7:0]]);
        check_eq(w ? "rdata_held_on_write" : "read_data", 32'(rdata[s]), 32'(exp_rd));
`ifdef DMEM_ADDR_CHECK_EN
        check_eq("addr_err_resp", 32'(aerr[s]), 32'(out_of_range(a)));
`endif
        last_rd[s] = exp_rd;
        if (w && !out_of_range(a)) model_mem[s][a[7:0]] = d;
        @(negedge clk);
        check_eq("valid_one_cycle", 32'(valid[s]), 32'd0);
        check_eq("idle_after_resp", 32'(busy[s]), 32'd0);
`ifdef DMEM_ADDR_CHECK_EN
        check_eq("addr_err_clear", 32'(aerr[s]), 32'd0);
`endif
    endtask

    initial begin
        int s;
        int nval;
        logic [15:0] a;
        rst = 1'b1;
        en = '0; wen_s = '0; addr = '0; wdata = '0;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_busy", 32'(busy[i]), 32'd0);
            check_eq("reset_valid", 32'(valid[i]), 32'd0);
            check_eq("reset_rdata", 32'(rdata[i]), 32'd0);
        end
        check_eq("reset_state0", 32'(st0), 32'(IDLE));
        check_eq("reset_state1", 32'(st1), 32'(IDLE));
        rst = 1'b0;

        // Give every word a known value so every later read has a defined expectation.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++)
                do_req(i, 1'b1, 16'(j), 16'($urandom));

        // Write/read-back at default latency, then immediate read-after-write at LATENCY=1.
        do_req(0, 1'b1, 16'd5, 16'h1234);
        do_req(0, 1'b0, 16'd5, 16'h0);
        do_req(1, 1'b1, 16'd3, 16'hAAAA);
        do_req(1, 1'b0, 16'd3, 16'h0);

        // Address 256: wraps onto 0 without checking; suppressed and flagged with checking.
        for (int i = 0; i < 2; i++) begin
            do_req(i, 1'b1, 16'd256, 16'h5555);
            do_req(i, 1'b0, 16'd0, 16'h0);
            do_req(i, 1'b0, 16'd256, 16'h0);
        end

        // Request strobe held for 12 edges: one acceptance every LATENCY+1 cycles.
        nval = 0;
        en[0] = 1'b1; wen_s[0] = 1'b0; addr[0] = 16'd5;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("held_busy", 32'(busy[0]), 32'((i % 3) != 2));
            check_eq("held_valid", 32'(valid[0]), 32'((i % 3) == 1));
            if (valid[0]) begin
                nval++;
                check_eq("held_rdata", 32'(rdata[0]), 32'(model_mem[0][5]));
            end
        end
        en[0] = 1'b0;
        last_rd[0] = model_mem[0][5];
        check_eq("held_requests", nval, 4);

        // Reset in the WAIT cycle of a write aborts it: no pulse, no commit.
        en[0] = 1'b1; wen_s[0] = 1'b1; addr[0] = 16'd7; wdata[0] = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0;
        check_eq("abort_in_wait", 32'(st0), 32'(WAIT));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy[0]), 32'd0);
        check_eq("abort_rdata0", 32'(rdata[0]), 32'd0);
        check_eq("abort_rdata1", 32'(rdata[1]), 32'd0);
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        nval = 0;
        repeat (4) begin
            @(negedge clk);
            nval += int'(valid[0]);
        end
        check_eq("abort_no_valid", nval, 0);
        do_req(0, 1'b0, 16'd7, 16'h0);

        // Reset and strobe on the same edge: the request is dropped.
        en[0] = 1'b1; rst = 1'b1; wen_s[0] = 1'b1; addr[0] = 16'd9; wdata[0] = ~model_mem[0][9];
        @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0; rst = 1'b0;
        check_eq("rst_wins_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        check_eq("rst_wins_valid", 32'(valid[0]), 32'd0);
        do_req(0, 1'b0, 16'd9, 16'h0);

        // Random mix of reads and writes across both instances and the full address space.
        repeat (150) begin
            s = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
            do_req(s, 1'($urandom_range(0, 1)), a, 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
